// File: rtl/dm_pkg.sv
// Shared definitions for the boot-time data-memory loader.
package dm_pkg;

    // Default data memory size in bytes (upper bound for the frame range check).
    localparam int MEM_BYTES_DEF = 1024;

    // Data memory access-type encoding.
    localparam logic [2:0] DM_BYTE  = 3'b000;
    localparam logic [2:0] DM_HALF  = 3'b001;
    localparam logic [2:0] DM_WORD  = 3'b010;
    localparam logic [2:0] DM_BYTEU = 3'b100;
    localparam logic [2:0] DM_HALFU = 3'b101;

    // Loader FSM states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_LEN   = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } ld_state_e;

endpackage

// File: rtl/dm_loader_if.sv
// Bundles used by the loader: the byte stream link and the memory write port.

// Byte stream link: the master offers bytes, the slave accepts them.
interface dm_rx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);
endinterface

// Data memory port: the master drives an access, the slave (memory) receives it.
interface dm_mem_if;
    logic [31:0] address;
    logic [31:0] data_wr;
    logic [2:0]  dm_ctrl;
    logic        dm_wr;

    modport master (output address, output data_wr, output dm_ctrl, output dm_wr);
    modport slave  (input  address, input  data_wr, input  dm_ctrl, input  dm_wr);
endinterface

// File: rtl/dm_port_mux.sv
// Selects which side drives the data memory port: the CPU when the loader
// is not busy, otherwise the loader.
module dm_port_mux (
    input  logic        busy,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_data_wr,
    input  logic [2:0]  cpu_dm_ctrl,
    input  logic        cpu_dm_wr,
    input  logic [31:0] ld_address,
    input  logic [31:0] ld_data_wr,
    input  logic [2:0]  ld_dm_ctrl,
    input  logic        ld_dm_wr,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_wr,
    output logic [2:0]  mem_dm_ctrl,
    output logic        mem_dm_wr
);

    // Route the owning side to the memory; CPU writes are dropped while busy.
    always_comb begin
        mem_address = cpu_address;
        mem_data_wr = cpu_data_wr;
        mem_dm_ctrl = cpu_dm_ctrl;
        mem_dm_wr   = cpu_dm_wr;
        if (busy) begin
            mem_address = ld_address;
            mem_data_wr = ld_data_wr;
            mem_dm_ctrl = ld_dm_ctrl;
            mem_dm_wr   = ld_dm_wr;
        end else begin
            mem_address = cpu_address;
            mem_data_wr = cpu_data_wr;
            mem_dm_ctrl = cpu_dm_ctrl;
            mem_dm_wr   = cpu_dm_wr;
        end
    end

endmodule

// File: rtl/dm_loader.sv
// Boot-time loader: parses a framed byte stream (base, length, payload) and
// writes the payload into data memory, stalling the CPU while it owns the port.
module dm_loader
    import dm_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int LEN_W     = 32
) (
    input  logic      Clk,
    input  logic      Rst,
    input  logic      Start,
    dm_rx_if.slave    rx,
    dm_mem_if.slave   cpu,
    dm_mem_if.master  mem,
    output logic      Busy,
    output logic      Done,
    output logic      Error
);

    ld_state_e         state_q, state_d;
    logic [LEN_W-1:0]  cur_q, cur_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [31:0]       word_q, word_d;

    logic              take_s;
    logic              single_s;
    logic [LEN_W-1:0]  len_s;
    logic [LEN_W-1:0]  step_s;
    logic [LEN_W-1:0]  rem_next_s;
    logic [LEN_W:0]    end_s;
    logic [31:0]       ld_address_s;
    logic [31:0]       ld_data_wr_s;
    logic [2:0]        ld_dm_ctrl_s;
    logic              ld_dm_wr_s;

    // State, counters and the word assembly register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            rem_q   <= '0;
            bcnt_q  <= 2'd0;
            word_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rem_q   <= rem_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
        end
    end

    // Status and stream-ready decode from the current state.
    always_comb begin
        Busy     = 1'b0;
        Done     = 1'b0;
        Error    = 1'b0;
        rx.ready = 1'b0;
        case (state_q)
            ST_ADDR, ST_LEN, ST_DATA: begin
                Busy     = 1'b1;
                rx.ready = 1'b1;
            end
            ST_WRITE: Busy  = 1'b1;
            ST_DONE:  Done  = 1'b1;
            ST_ERR:   Error = 1'b1;
            default: begin
                Busy     = 1'b0;
                rx.ready = 1'b0;
            end
        endcase
    end

    // Next-state logic, header/payload capture and the loader's port drive.
    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        rem_d        = rem_q;
        bcnt_d       = bcnt_q;
        word_d       = word_q;
        take_s       = rx.valid & rx.ready;
        single_s     = (rem_q < LEN_W'(4));
        step_s       = single_s ? LEN_W'(1) : LEN_W'(4);
        rem_next_s   = rem_q - step_s;
        len_s        = {rem_q[LEN_W-9:0], rx.data};
        // Frame end computed one bit wider so base + len cannot wrap.
        end_s        = {1'b0, cur_q} + {1'b0, len_s};
        ld_address_s = 32'(cur_q);
        ld_data_wr_s = 32'd0;
        ld_dm_ctrl_s = DM_WORD;
        ld_dm_wr_s   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (Start) begin
                    state_d = ST_ADDR;
                    bcnt_d  = 2'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_ADDR: begin
                if (take_s) begin
                    cur_d  = {cur_q[LEN_W-9:0], rx.data};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_d = ST_LEN;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_LEN: begin
                if (take_s) begin
                    rem_d  = len_s;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q != 2'd3) begin
                        state_d = ST_LEN;
                    end else if (end_s > (LEN_W+1)'(MEM_BYTES)) begin
                        state_d = ST_ERR;
                    end else if (len_s == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_LEN;
                end
            end
            ST_DATA: begin
                if (take_s && single_s) begin
                    // Tail byte: sits in the low lane for a byte store.
                    word_d  = {24'd0, rx.data};
                    bcnt_d  = 2'd0;
                    state_d = ST_WRITE;
                end else if (take_s) begin
                    // First byte of a word goes to the top lane (lowest address).
                    case (bcnt_q)
                        2'd0:    word_d[31:24] = rx.data;
                        2'd1:    word_d[23:16] = rx.data;
                        2'd2:    word_d[15:8]  = rx.data;
                        default: word_d[7:0]   = rx.data;
                    endcase
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_WRITE: begin
                ld_dm_wr_s   = 1'b1;
                ld_data_wr_s = word_q;
                ld_dm_ctrl_s = single_s ? DM_BYTE : DM_WORD;
                cur_d        = cur_q + step_s;
                rem_d        = rem_next_s;
                bcnt_d       = 2'd0;
                if (rem_next_s == '0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    dm_port_mux u_mux (
        .busy        (Busy),
        .cpu_address (cpu.address),
        .cpu_data_wr (cpu.data_wr),
        .cpu_dm_ctrl (cpu.dm_ctrl),
        .cpu_dm_wr   (cpu.dm_wr),
        .ld_address  (ld_address_s),
        .ld_data_wr  (ld_data_wr_s),
        .ld_dm_ctrl  (ld_dm_ctrl_s),
        .ld_dm_wr    (ld_dm_wr_s),
        .mem_address (mem.address),
        .mem_data_wr (mem.data_wr),
        .mem_dm_ctrl (mem.dm_ctrl),
        .mem_dm_wr   (mem.dm_wr)
    );

endmodule

// File: tb/tb_dm_loader.sv
// Directed bench for dm_loader with a write scoreboard and a byte memory model.
module tb_dm_loader;
    import dm_pkg::*;

    logic Clk = 1'b0;
    logic Rst;
    logic Start;
    logic Busy, Done, Error;

    dm_rx_if  rx ();
    dm_mem_if cpu ();
    dm_mem_if mem ();

    dm_loader #(.MEM_BYTES(1024), .LEN_W(32)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Start (Start),
        .rx    (rx),
        .cpu   (cpu),
        .mem   (mem),
        .Busy  (Busy),
        .Done  (Done),
        .Error (Error)
    );

    always #5 Clk = ~Clk;

    // Byte-addressed data memory model; word stores put data[31:24] at the lowest address.
    logic [7:0] tb_mem [0:1023];
    always @(posedge Clk) begin
        if (mem.dm_wr === 1'b1) begin
            case (mem.dm_ctrl)
                DM_WORD: begin
                    tb_mem[mem.address[9:0]]         <= mem.data_wr[31:24];
                    tb_mem[mem.address[9:0] + 10'd1] <= mem.data_wr[23:16];
                    tb_mem[mem.address[9:0] + 10'd2] <= mem.data_wr[15:8];
                    tb_mem[mem.address[9:0] + 10'd3] <= mem.data_wr[7:0];
                end
                DM_HALF, DM_HALFU: begin
                    tb_mem[mem.address[9:0]]         <= mem.data_wr[15:8];
                    tb_mem[mem.address[9:0] + 10'd1] <= mem.data_wr[7:0];
                end
                default: tb_mem[mem.address[9:0]] <= mem.data_wr[7:0];
            endcase
        end
    end

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return {tb_mem[a[9:0]], tb_mem[a[9:0] + 10'd1], tb_mem[a[9:0] + 10'd2], tb_mem[a[9:0] + 10'd3]};
    endfunction

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    logic [66:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: at the falling edge score any loader write and sample ready,
    // then return just after the rising edge.
    task automatic tick(output logic rdy);
        logic [66:0] e;
        @(negedge Clk);
        rdy = rx.ready;
        if (mem.dm_wr === 1'b1 && Busy === 1'b1) begin
            wr_cnt++;
            n_cmp++;
            assert (exp_q.size() > 0) else begin
                n_err++;
                $error("FAIL unexpected_write: observed addr=%h data=%h ctrl=%b expected none",
                       mem.address, mem.data_wr, mem.dm_ctrl);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                assert ({mem.address, mem.data_wr, mem.dm_ctrl} === e) else begin
                    n_err++;
                    $error("FAIL write: observed %h/%h/%b expected %h/%h/%b",
                           mem.address, mem.data_wr, mem.dm_ctrl, e[66:35], e[34:3], e[2:0]);
                end
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic step();
        logic r;
        tick(r);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        logic r;
        bit ok;
        ok = 1'b0;
        if (gap) begin
            rx.valid = 1'b0;
            tick(r);
        end
        rx.data  = b;
        rx.valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick(r);
            if (r === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        rx.valid = 1'b0;
        n_cmp++;
        assert (ok) else begin
            n_err++;
            $error("FAIL accept_timeout: observed not accepted expected accepted byte %h", b);
        end
    endtask

    task automatic send_word(input logic [31:0] v, input bit gap);
        send_byte(v[31:24], gap);
        send_byte(v[23:16], gap);
        send_byte(v[15:8],  gap);
        send_byte(v[7:0],   gap);
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        step();
        Start = 1'b0;
        wr_cnt = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 32; i++) begin
            if (Busy === 1'b0) break;
            step();
        end
        chk("idle_timeout", {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) tb_mem[i] = 8'h00;
        Rst = 1'b1; Start = 1'b0;
        rx.data = 8'h00; rx.valid = 1'b0;
        cpu.address = 32'h0000_0123; cpu.data_wr = 32'h0; cpu.dm_ctrl = 3'b001; cpu.dm_wr = 1'b0;
        #2;
        // Reset state and passthrough.
        chk("rst_busy",  {31'd0, Busy},     32'd0);
        chk("rst_done",  {31'd0, Done},     32'd0);
        chk("rst_error", {31'd0, Error},    32'd0);
        chk("rst_ready", {31'd0, rx.ready}, 32'd0);
        chk("rst_pass_addr", mem.address, 32'h0000_0123);
        chk("rst_pass_ctrl", {29'd0, mem.dm_ctrl}, 32'd1);
        step(); step();
        Rst = 1'b0;
        step();

        // 1: two aligned words.
        pulse_start();
        chk("t1_busy", {31'd0, Busy}, 32'd1);
        exp_q.push_back({32'h10, 32'h1122_3344, DM_WORD});
        exp_q.push_back({32'h14, 32'h5566_7788, DM_WORD});
        send_word(32'h10, 1'b0);
        send_word(32'h08, 1'b0);
        send_word(32'h1122_3344, 1'b0);
        send_word(32'h5566_7788, 1'b0);
        wait_idle();
        chk("t1_done",   {31'd0, Done}, 32'd1);
        chk("t1_writes", wr_cnt, 32'd2);
        chk("t1_queue",  exp_q.size(), 32'd0);

        // 2: one word plus two tail bytes.
        pulse_start();
        exp_q.push_back({32'h20, 32'hAABB_CCDD, DM_WORD});
        exp_q.push_back({32'h24, 32'h0000_00EE, DM_BYTE});
        exp_q.push_back({32'h25, 32'h0000_00FF, DM_BYTE});
        send_word(32'h20, 1'b0);
        send_word(32'h06, 1'b0);
        send_word(32'hAABB_CCDD, 1'b0);
        send_byte(8'hEE, 1'b0);
        send_byte(8'hFF, 1'b0);
        wait_idle();
        chk("t2_done",   {31'd0, Done}, 32'd1);
        chk("t2_writes", wr_cnt, 32'd3);
        chk("t2_mem",    rd_word(32'h24), 32'hEEFF_0000);

        // 3: zero length finishes right after the header.
        pulse_start();
        send_word(32'h40, 1'b0);
        send_word(32'h00, 1'b0);
        chk("t3_done",   {31'd0, Done}, 32'd1);
        chk("t3_busy",   {31'd0, Busy}, 32'd0);
        step(); step();
        chk("t3_writes", wr_cnt, 32'd0);

        // 4: frame past the end of memory is rejected; exact fit is accepted.
        pulse_start();
        send_word(32'h3FC, 1'b0);
        send_word(32'h08, 1'b0);
        step();
        chk("t4_error", {31'd0, Error},    32'd1);
        chk("t4_ready", {31'd0, rx.ready}, 32'd0);
        chk("t4_busy",  {31'd0, Busy},     32'd0);
        chk("t4_writes", wr_cnt, 32'd0);
        pulse_start();
        chk("t4_err_clr", {31'd0, Error}, 32'd0);
        exp_q.push_back({32'h3FC, 32'hCAFE_F00D, DM_WORD});
        send_word(32'h3FC, 1'b0);
        send_word(32'h04, 1'b0);
        send_word(32'hCAFE_F00D, 1'b0);
        wait_idle();
        chk("t4_done2",  {31'd0, Done},  32'd1);
        chk("t4_error2", {31'd0, Error}, 32'd0);
        chk("t4_writes2", wr_cnt, 32'd1);

        // 5: CPU write held during a load is ignored; passthrough afterwards.
        cpu.address = 32'h80; cpu.data_wr = 32'hDEAD_BEEF; cpu.dm_ctrl = DM_WORD; cpu.dm_wr = 1'b1;
        pulse_start();
        chk("t5_stall_wr",   {31'd0, mem.dm_wr}, 32'd0);
        chk("t5_stall_ctrl", {29'd0, mem.dm_ctrl}, {29'd0, DM_WORD});
        chk("t5_stall_data", mem.data_wr, 32'd0);
        exp_q.push_back({32'h100, 32'h0102_0304, DM_WORD});
        send_word(32'h100, 1'b0);
        send_word(32'h04, 1'b0);
        send_word(32'h0102_0304, 1'b0);
        wait_idle();
        cpu.dm_wr = 1'b0; cpu.address = 32'h10; cpu.dm_ctrl = DM_WORD;
        #1;
        chk("t5_writes",    wr_cnt, 32'd1);
        chk("t5_pass_addr", mem.address, 32'h10);
        chk("t5_pass_ctrl", {29'd0, mem.dm_ctrl}, {29'd0, DM_WORD});
        chk("t5_pass_wr",   {31'd0, mem.dm_wr}, 32'd0);
        chk("t5_read",      rd_word(mem.address), 32'h1122_3344);

        // 6: reset mid-word with a gappy stream discards the partial word.
        cpu.address = 32'h200; cpu.dm_ctrl = DM_BYTEU;
        pulse_start();
        send_word(32'h30, 1'b1);
        send_word(32'h04, 1'b1);
        send_byte(8'h99, 1'b1);
        send_byte(8'h98, 1'b1);
        Rst = 1'b1;
        #1;
        chk("t6_busy",  {31'd0, Busy},     32'd0);
        chk("t6_done",  {31'd0, Done},     32'd0);
        chk("t6_ready", {31'd0, rx.ready}, 32'd0);
        chk("t6_pass_addr", mem.address, 32'h200);
        chk("t6_pass_ctrl", {29'd0, mem.dm_ctrl}, {29'd0, DM_BYTEU});
        step();
        Rst = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("t6_writes", wr_cnt, 32'd0);
        chk("t6_mem",    rd_word(32'h30), 32'd0);
        chk("t6_idle",   {30'd0, Busy, Done}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
